// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared opcodes and state encoding for the multiply/divide unit
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MFHI  = 3'd4;
    localparam logic [2:0] MD_MFLO  = 3'd5;
    localparam logic [2:0] MD_MTHI  = 3'd6;
    localparam logic [2:0] MD_MTLO  = 3'd7;

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide result generator, sampled once at start
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        prod   = 64'd0;
        quo    = 32'd0;
        rem    = 32'd0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        mag_a  = a[31] ? (32'd0 - a) : a;
        mag_b  = b[31] ? (32'd0 - b) : b;
        case (md_op)
            MD_MULT: begin
                prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    div0 = 1'b1;
                end else begin
                    quo    = mag_a / mag_b;
                    rem    = mag_a % mag_b;
                    res_lo = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
                    res_hi = a[31] ? (32'd0 - rem) : rem;
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div0 = 1'b1;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: begin
                div0 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit with HI/LO registers and D-stage stall request
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata,
    output logic        stall_md
);

    md_state_t        state;
    md_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_div0;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div0;
    logic             is_div;
    logic             load;
    logic             commit;
    logic             mt_hi;
    logic             mt_lo;

    md_calc u_calc (
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A start or move-to while RUN is a protocol error and is dropped.
    always_comb begin
        busy   = (state == RUN);
        load   = (state == IDLE) && start;
        commit = (state == RUN) && (cnt == CNT_W'(1));
        mt_hi  = (state == IDLE) && !start && (md_op == MD_MTHI);
        mt_lo  = (state == IDLE) && !start && (md_op == MD_MTLO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            if (load) begin
                pend_hi   <= res_hi;
                pend_lo   <= res_lo;
                pend_div0 <= div0;
                cnt       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit && !pend_div0) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
        end
    end

    always_comb begin
        case (md_op)
            MD_MFHI: md_rdata = hi;
            MD_MFLO: md_rdata = lo;
            default: md_rdata = 32'd0;
        endcase
    end

    assign stall_md = d_is_md && (start || busy);

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against a behavioural HI/LO model
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_is_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;
    logic        stall_md;

    int checks = 0;
    int failures = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_rdata (md_rdata),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural HI/LO plus a pending result that lands after L busy cycles.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    bit          m_pvalid = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        longint sa, sb;
        logic [63:0] up;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pvalid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pvalid) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            m_pvalid = 1'b1;
            m_left = (md_op == MD_DIV || md_op == MD_DIVU) ? 10 : 5;
            case (md_op)
                MD_MULT: begin
                    up = 64'(sa * sb);
                    {m_phi, m_plo} = up;
                end
                MD_MULTU: begin
                    up = {32'd0, a} * {32'd0, b};
                    {m_phi, m_plo} = up;
                end
                MD_DIV: begin
                    if (b == 0) m_pvalid = 1'b0;
                    else begin
                        m_plo = 32'(sa / sb);
                        m_phi = 32'(sa % sb);
                    end
                end
                default: begin
                    if (b == 0) m_pvalid = 1'b0;
                    else begin
                        m_plo = a / b;
                        m_phi = a % b;
                    end
                end
            endcase
        end else if (md_op == MD_MTHI) begin
            m_hi = a;
        end else if (md_op == MD_MTLO) begin
            m_lo = a;
        end
    end

    always @(negedge clk) begin
        logic        e_busy;
        logic [31:0] e_rd;
        e_busy = (m_left > 0);
        e_rd = (md_op == MD_MFHI) ? m_hi : (md_op == MD_MFLO) ? m_lo : 32'd0;
        check("cmp_busy", {31'd0, busy}, {31'd0, e_busy});
        check("cmp_hi", hi, m_hi);
        check("cmp_lo", lo, m_lo);
        check("cmp_rdata", md_rdata, e_rd);
        check("cmp_stall", {31'd0, stall_md}, {31'd0, d_is_md && (start || e_busy)});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic dmd, output int nbusy, output int nstall);
        tick();
        start = 1'b1; md_op = op; a = va; b = vb; d_is_md = dmd;
        @(negedge clk);
        nstall = int'(stall_md);
        nbusy = 0;
        tick();
        start = 1'b0; md_op = MD_MFLO;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            nstall += int'(stall_md);
        end
        check("stall_after_done", {31'd0, stall_md}, 32'd0);
    endtask

    int nb, ns;

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_MFHI; a = 0; b = 0; d_is_md = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_rdata", md_rdata, 32'd0);
        check("rst_stall", {31'd0, stall_md}, 32'd0);
        tick();
        reset = 1'b0;

        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, nb, ns);
        check("mult_busy_cycles", nb, 5);
        check("mult_stall_cycles", ns, 6);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        issue(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, nb, ns);
        check("multu_stall_cycles", ns, 0);
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, nb, ns);
        check("div_busy_cycles", nb, 10);
        check("div_stall_cycles", ns, 11);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        issue(MD_DIVU, 32'd7, 32'd2, 1'b0, nb, ns);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb, ns);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'd0);

        tick(); md_op = MD_MTHI; a = 32'h1234;
        tick(); md_op = MD_MTLO; a = 32'h5678;
        issue(MD_DIV, 32'd99, 32'd0, 1'b1, nb, ns);
        check("div0_busy_cycles", nb, 10);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'h5678);
        md_op = MD_MFHI;
        @(negedge clk);
        check("mfhi_rdata", md_rdata, 32'h1234);
        tick(); md_op = MD_MFLO;
        @(negedge clk);
        check("mflo_rdata", md_rdata, 32'h5678);

        // Stray start and MTLO while running must not disturb the DIVU in flight.
        tick();
        start = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd7;
        nb = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            start = 1'b0; md_op = MD_MFLO;
            if (i == 2) begin start = 1'b1; md_op = MD_MULT; a = 32'd2; b = 32'd3; end
            if (i == 4) begin md_op = MD_MTLO; a = 32'hDEAD; end
            @(negedge clk);
            if (!busy) break;
            nb++;
        end
        check("proto_busy_cycles", nb, 10);
        check("proto_lo", lo, 32'd14);
        check("proto_hi", hi, 32'd2);

        tick();
        start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd3;
        tick(); start = 1'b0; md_op = MD_MFLO;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (15) tick();
        @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
